// File: rtl/hier_xbar_one_hot_pipe_if.sv
// rtl/hier_xbar_one_hot_pipe_if.sv - lane, command and status bundle for the one-hot crossbar
interface hier_xbar_one_hot_pipe_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_INPUT_DATA  = 32,
  parameter int NUM_OUTPUT_DATA = 8
);
  logic [NUM_INPUT_DATA-1:0]                 i_valid;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]      i_data_bus;
  logic                                      i_en;
  logic                                      i_cmd_load;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd;
  logic                                      i_err_clr;
  logic [NUM_OUTPUT_DATA-1:0]                o_valid;
  logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0]     o_data_bus;
  logic [NUM_OUTPUT_DATA-1:0]                o_err;

  modport master (
    output i_valid, i_data_bus, i_en, i_cmd_load, i_cmd, i_err_clr,
    input  o_valid, o_data_bus, o_err
  );

  modport slave (
    input  i_valid, i_data_bus, i_en, i_cmd_load, i_cmd, i_err_clr,
    output o_valid, o_data_bus, o_err
  );
endinterface

// File: rtl/hier_xbar_one_hot_pipe.sv
// rtl/hier_xbar_one_hot_pipe.sv - pipelined MUX_RADIX-ary tree crossbar with one-hot routes and conflict flags
module hier_xbar_one_hot_pipe #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_INPUT_DATA  = 32,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int MUX_RADIX       = 2
) (
  input logic                     clk,
  input logic                     rst,
  hier_xbar_one_hot_pipe_if.slave bus
);
  localparam int LOG_R     = $clog2(MUX_RADIX);
  localparam int NUM_STAGE = $clog2(NUM_INPUT_DATA) / LOG_R;
  localparam int NODES     = NUM_INPUT_DATA / MUX_RADIX;

  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] cmd_reg;
  logic [NUM_OUTPUT_DATA-1:0]                seen;
  logic [NUM_OUTPUT_DATA-1:0]                conflict;
  logic [NUM_OUTPUT_DATA-1:0]                err;

  logic                  leaf_v [NUM_OUTPUT_DATA][NUM_INPUT_DATA];
  logic [DATA_WIDTH-1:0] leaf_d [NUM_OUTPUT_DATA][NUM_INPUT_DATA];
  logic                  stg_v  [NUM_OUTPUT_DATA][NUM_STAGE][NODES];
  logic [DATA_WIDTH-1:0] stg_d  [NUM_OUTPUT_DATA][NUM_STAGE][NODES];
  logic                  nxt_v  [NUM_OUTPUT_DATA][NUM_STAGE][NODES];
  logic [DATA_WIDTH-1:0] nxt_d  [NUM_OUTPUT_DATA][NUM_STAGE][NODES];

  // A column conflicts once a second set bit is seen in it.
  always_comb begin
    seen     = '0;
    conflict = '0;
    for (int o = 0; o < NUM_OUTPUT_DATA; o++) begin
      for (int k = 0; k < NUM_INPUT_DATA; k++) begin
        conflict[o] = conflict[o] | (seen[o] & cmd_reg[k*NUM_OUTPUT_DATA+o]);
        seen[o]     = seen[o] | cmd_reg[k*NUM_OUTPUT_DATA+o];
      end
    end
  end

  // Invalid leaves carry zero data so every tree node can be a plain OR.
  always_comb begin
    for (int o = 0; o < NUM_OUTPUT_DATA; o++) begin
      for (int k = 0; k < NUM_INPUT_DATA; k++) begin
        leaf_v[o][k] = bus.i_valid[k] & cmd_reg[k*NUM_OUTPUT_DATA+o] & ~conflict[o];
        leaf_d[o][k] = leaf_v[o][k] ? bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_OUTPUT_DATA; o++) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        for (int n = 0; n < NODES; n++) begin
          nxt_v[o][s][n] = 1'b0;
          nxt_d[o][s][n] = '0;
        end
      end
      for (int n = 0; n < NODES; n++) begin
        for (int c = 0; c < MUX_RADIX; c++) begin
          nxt_v[o][0][n] = nxt_v[o][0][n] | leaf_v[o][n*MUX_RADIX+c];
          nxt_d[o][0][n] = nxt_d[o][0][n] | leaf_d[o][n*MUX_RADIX+c];
        end
      end
      // Node count shrinks by MUX_RADIX per stage; slots beyond it stay zero.
      for (int s = 1; s < NUM_STAGE; s++) begin
        for (int n = 0; n < NODES; n++) begin
          if (n < (NUM_INPUT_DATA >> (LOG_R*(s+1)))) begin
            for (int c = 0; c < MUX_RADIX; c++) begin
              nxt_v[o][s][n] = nxt_v[o][s][n] | stg_v[o][s-1][n*MUX_RADIX+c];
              nxt_d[o][s][n] = nxt_d[o][s][n] | stg_d[o][s-1][n*MUX_RADIX+c];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_reg <= '0;
      err     <= '0;
      stg_v   <= '{default: '0};
      stg_d   <= '{default: '0};
    end else begin
      if (bus.i_cmd_load) begin
        cmd_reg <= bus.i_cmd;
      end
      err <= (err & ~{NUM_OUTPUT_DATA{bus.i_err_clr}}) | conflict;
      if (bus.i_en) begin
        stg_v <= nxt_v;
        stg_d <= nxt_d;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_OUTPUT_DATA; o++) begin
      bus.o_valid[o]                             = stg_v[o][NUM_STAGE-1][0];
      bus.o_data_bus[o*DATA_WIDTH +: DATA_WIDTH] = stg_d[o][NUM_STAGE-1][0];
    end
  end

  assign bus.o_err = err;
endmodule

// File: tb/tb_hier_xbar_one_hot_pipe.sv
// tb/tb_hier_xbar_one_hot_pipe.sv - directed bench with a route-level reference model for the one-hot crossbar
module tb_hier_xbar_one_hot_pipe;
  localparam int DW  = 32;
  localparam int NI  = 32;
  localparam int NO  = 8;
  localparam int LAT = 5;
  localparam int NIB = 16;
  localparam int NOB = 4;
  localparam logic [NI-1:0]  ALL_A = '1;
  localparam logic [NIB-1:0] ALL_B = '1;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  always #5 clk = ~clk;

  hier_xbar_one_hot_pipe_if #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO)) a_if ();
  hier_xbar_one_hot_pipe_if #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NIB), .NUM_OUTPUT_DATA(NOB)) b_if ();

  hier_xbar_one_hot_pipe #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO), .MUX_RADIX(2))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  hier_xbar_one_hot_pipe #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NIB), .NUM_OUTPUT_DATA(NOB), .MUX_RADIX(4))
    dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: each enabled edge produces one beat per output from the routing table, then a delay line.
  logic [NI*NO-1:0] m_cmd;
  logic [NO-1:0]    m_err;
  logic             m_v [LAT][NO];
  logic [DW-1:0]    m_d [LAT][NO];

  always @(posedge clk or negedge rst) begin : model
    int cnt;
    int sel;
    logic          bv [NO];
    logic [DW-1:0] bd [NO];
    logic [NO-1:0] cf;
    if (!rst) begin
      m_cmd = '0;
      m_err = '0;
      for (int s = 0; s < LAT; s++)
        for (int o = 0; o < NO; o++) begin
          m_v[s][o] = 1'b0;
          m_d[s][o] = '0;
        end
    end else begin
      for (int o = 0; o < NO; o++) begin
        cnt = 0;
        sel = 0;
        for (int k = 0; k < NI; k++)
          if (m_cmd[k*NO+o]) begin
            cnt++;
            sel = k;
          end
        cf[o] = (cnt > 1);
        bv[o] = (cnt == 1) && a_if.i_valid[sel];
        bd[o] = bv[o] ? a_if.i_data_bus[sel*DW +: DW] : '0;
      end
      if (a_if.i_en) begin
        for (int s = LAT-1; s > 0; s--)
          for (int o = 0; o < NO; o++) begin
            m_v[s][o] = m_v[s-1][o];
            m_d[s][o] = m_d[s-1][o];
          end
        for (int o = 0; o < NO; o++) begin
          m_v[0][o] = bv[o];
          m_d[0][o] = bd[o];
        end
      end
      m_err = (m_err & ~{NO{a_if.i_err_clr}}) | cf;
      if (a_if.i_cmd_load) m_cmd = a_if.i_cmd;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int o = 0; o < NO; o++) begin
        check($sformatf("cmp_valid[%0d]", o), 64'(a_if.o_valid[o]), 64'(m_v[LAT-1][o]));
        check($sformatf("cmp_data[%0d]", o), 64'(a_if.o_data_bus[o*DW +: DW]), 64'(m_d[LAT-1][o]));
        check($sformatf("cmp_err[%0d]", o), 64'(a_if.o_err[o]), 64'(m_err[o]));
      end
    end
  end

  task automatic drive_a(input logic [NI-1:0] v, input int tag);
    a_if.i_valid = v;
    for (int k = 0; k < NI; k++) a_if.i_data_bus[k*DW +: DW] = (tag << 8) | k;
  endtask

  function automatic logic [NI*NO-1:0] perm(input int off, input bit rev);
    logic [NI*NO-1:0] c;
    int k;
    c = '0;
    for (int o = 0; o < NO; o++) begin
      k = rev ? 4*(NO-1-o) + off : 4*o + off;
      c[k*NO+o] = 1'b1;
    end
    return c;
  endfunction

  logic [NI*NO-1:0] cmd_cf;
  logic [NIB*NOB-1:0] cmd_b;

  initial begin
    rst = 1'b0;
    rst_b = 1'b0;
    a_if.i_valid = '0; a_if.i_data_bus = '0; a_if.i_en = 1'b1;
    a_if.i_cmd_load = 1'b0; a_if.i_cmd = '0; a_if.i_err_clr = 1'b0;
    b_if.i_valid = '0; b_if.i_data_bus = '0; b_if.i_en = 1'b1;
    b_if.i_cmd_load = 1'b0; b_if.i_cmd = '0; b_if.i_err_clr = 1'b0;

    // Reset and idle: random traffic never reaches the outputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_if.i_valid = $urandom;
      for (int k = 0; k < NI; k++) a_if.i_data_bus[k*DW +: DW] = $urandom;
    end
    check("rst_valid", 64'(a_if.o_valid), 64'h0);
    check("rst_data", 64'(|a_if.o_data_bus), 64'h0);
    check("rst_err", 64'(a_if.o_err), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_if.i_valid = $urandom;
      for (int k = 0; k < NI; k++) a_if.i_data_bus[k*DW +: DW] = $urandom;
    end
    check("idle_valid", 64'(a_if.o_valid), 64'h0);
    check("idle_data", 64'(|a_if.o_data_bus), 64'h0);

    // Permutation input 4o+1 -> output o, with a valid gap every third beat.
    @(negedge clk);
    a_if.i_cmd = perm(1, 0);
    a_if.i_cmd_load = 1'b1;
    drive_a('0, 0);
    @(negedge clk);
    a_if.i_cmd_load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 25) check("perm_gap_valid", 64'(a_if.o_valid), 64'h0);
      if (i == 26) begin
        check("perm_valid", 64'(a_if.o_valid), 64'hFF);
        check("perm_lane0", 64'(a_if.o_data_bus[0 +: DW]), 64'((1021 << 8) | 1));
        check("perm_lane7", 64'(a_if.o_data_bus[7*DW +: DW]), 64'((1021 << 8) | 29));
      end
      drive_a((i % 3 == 2) ? '0 : ALL_A, 1000 + i);
    end

    // Stall for three edges in the middle of a dense stream.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 11) check("stall_hold_lane0", 64'(a_if.o_data_bus[0 +: DW]), 64'((2003 << 8) | 1));
      if (i == 12) check("stall_resume_lane0", 64'(a_if.o_data_bus[0 +: DW]), 64'((2004 << 8) | 1));
      a_if.i_en = !(i >= 8 && i <= 10);
      drive_a(ALL_A, 2000 + i);
    end
    a_if.i_en = 1'b1;

    // Inputs 3 and 17 both routed to output 2.
    cmd_cf = perm(1, 0);
    cmd_cf[9*NO+2] = 1'b0;
    cmd_cf[3*NO+2] = 1'b1;
    cmd_cf[17*NO+2] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      a_if.i_cmd_load = 1'b0;
      a_if.i_err_clr = 1'b0;
      case (j)
        0: begin a_if.i_cmd = cmd_cf; a_if.i_cmd_load = 1'b1; end
        2: check("cf_err_set", 64'(a_if.o_err), 64'h04);
        8: begin
          check("cf_valid", 64'(a_if.o_valid), 64'hFB);
          a_if.i_err_clr = 1'b1;
        end
        10: begin
          check("cf_err_sticky", 64'(a_if.o_err), 64'h04);
          a_if.i_cmd = perm(1, 0);
          a_if.i_cmd_load = 1'b1;
        end
        12: a_if.i_err_clr = 1'b1;
        13: check("cf_err_cleared", 64'(a_if.o_err), 64'h00);
        default: ;
      endcase
      drive_a(ALL_A, 3000 + j);
    end

    // Routes swap every two cycles while beats are in flight.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        a_if.i_cmd = ((i / 2) % 2 == 1) ? perm(2, 1) : perm(1, 0);
        a_if.i_cmd_load = 1'b1;
      end else begin
        a_if.i_cmd_load = 1'b0;
      end
      drive_a(NI'($urandom), 4000 + i);
    end
    a_if.i_cmd_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_a('0, 0);
    end

    // Radix 4, 16x4: broadcast input 9, then asynchronous reset mid-stream.
    cmd_b = '0;
    for (int o = 0; o < NOB; o++) cmd_b[9*NOB+o] = 1'b1;
    for (int k = 0; k < NIB; k++) b_if.i_data_bus[k*DW +: DW] = 32'hB000_0000 + k;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_idle_valid", 64'(b_if.o_valid), 64'h0);
    b_if.i_cmd = cmd_b;
    b_if.i_cmd_load = 1'b1;
    @(negedge clk);
    b_if.i_cmd_load = 1'b0;
    b_if.i_valid = ALL_B;
    @(negedge clk);
    @(negedge clk);
    check("b_valid", 64'(b_if.o_valid), 64'hF);
    for (int o = 0; o < NOB; o++)
      check($sformatf("b_lane%0d", o), 64'(b_if.o_data_bus[o*DW +: DW]), 64'h0000_0000_B000_0009);
    check("b_err", 64'(b_if.o_err), 64'h0);
    #2;
    rst_b = 1'b0;
    #1;
    check("b_async_valid", 64'(b_if.o_valid), 64'h0);
    check("b_async_data", 64'(|b_if.o_data_bus), 64'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
